// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port asynchronous-read memory,
// with an optional write-protected (ROM) address window. One access per three cycles.
module mem_arbiter #(
    parameter int                ADDR_W = 15,
    parameter int                DATA_W = 8,
    parameter bit                WP_EN  = 1'b0,
    parameter logic [ADDR_W-1:0] WP_LO  = 15'h0000,
    parameter logic [ADDR_W-1:0] WP_HI  = 15'h7FFF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,

    output logic              busy,
    output logic              mem_write_enable,
    output logic              mem_output_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t              state_q;
    logic                last_grant_q;   // 0 = A, 1 = B; also selects the requester being served
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                we_q;
    logic                prot_q;
    logic [DATA_W-1:0]   a_rdata_q, b_rdata_q;
    logic                a_ack_q, b_ack_q, a_err_q, b_err_q;

    logic                grant_b_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic                we_d;
    logic                prot_d;

    // Two extra sign bits keep the window compares meaningful even when the
    // window spans the whole address space.
    logic signed [ADDR_W+1:0] addr_s, lo_s, hi_s;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // one unassigned, which would otherwise infer a latch.
        grant_b_d = b_req;
        if (a_req && b_req) begin
            grant_b_d = ~last_grant_q;
        end
        addr_d  = grant_b_d ? b_addr  : a_addr;
        wdata_d = grant_b_d ? b_wdata : a_wdata;
        we_d    = grant_b_d ? b_we    : a_we;
    end

    assign addr_s = $signed({2'b00, addr_d});
    assign lo_s   = $signed({2'b00, WP_LO});
    assign hi_s   = $signed({2'b00, WP_HI});
    assign prot_d = WP_EN && we_d && (addr_s >= lo_s) && (addr_s <= hi_s);

    // NOTE: all state is updated with non-blocking assignments so every register
    // sees the pre-edge value of every other register, matching real flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            prot_q       <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_err_q      <= 1'b0;
            b_err_q      <= 1'b0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            a_err_q <= 1'b0;
            b_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (a_req || b_req) begin
                        state_q      <= ACCESS;
                        last_grant_q <= grant_b_d;
                        addr_q       <= addr_d;
                        wdata_q      <= wdata_d;
                        we_q         <= we_d;
                        prot_q       <= prot_d;
                    end
                end
                ACCESS: begin
                    state_q <= ACK;
                    if (!we_q) begin
                        if (last_grant_q) b_rdata_q <= mem_data_out;
                        else              a_rdata_q <= mem_data_out;
                    end
                    a_ack_q <= ~last_grant_q;
                    b_ack_q <= last_grant_q;
                    a_err_q <= ~last_grant_q & prot_q;
                    b_err_q <= last_grant_q & prot_q;
                end
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes and completion flags are masked by reset so an access caught by
    // reset mid-flight never writes memory and never reports completion.
    assign mem_output_enable = ~reset & (state_q == ACCESS) & ~we_q;
    assign mem_write_enable  = ~reset & (state_q == ACCESS) & we_q & ~prot_q;
    assign mem_address       = addr_q;
    assign mem_data_in       = wdata_q;

    assign busy    = (state_q != IDLE);
    assign a_ack   = a_ack_q & ~reset;
    assign b_ack   = b_ack_q & ~reset;
    assign a_err   = a_err_q & ~reset;
    assign b_err   = b_err_q & ~reset;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model compared every cycle,
// plus directed transfers with hand-computed expectations.
module tb_mem_arbiter;

    localparam int AW = 15;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ack, b_ack, a_err, b_err, busy;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          mem_write_enable, mem_output_enable;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in, mem_data_out;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .WP_EN(1'b1), .WP_LO(15'h1000), .WP_HI(15'h1FFF)
    ) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .busy(busy),
        .mem_write_enable(mem_write_enable), .mem_output_enable(mem_output_enable),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // External memory driven by the DUT strobes.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    assign mem_data_out = mem[mem_address];

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[15'h1FFD] = 8'h77;
        mem[15'h0300] = 8'h33;
        forever begin
            @(posedge clk);
            if (mem_write_enable) mem[mem_address] <= mem_data_in;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction described by who/what and its
    // age in cycles since the grant (-1 = none). Memory effects happen one cycle
    // after the grant, completion is visible two cycles after it.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            m_live = 1'b0;
    int            m_age  = -1;
    bit            m_last = 1'b1;
    bit            m_who  = 1'b0;
    bit            m_we   = 1'b0;
    bit            m_prot = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rd_a = '0, m_rd_b = '0;

    initial begin
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
        ref_mem[15'h1FFD] = 8'h77;
        ref_mem[15'h0300] = 8'h33;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_live = 1'b1;
                m_age  = -1;
                m_last = 1'b1;
                m_addr = '0;
                m_wdata = '0;
                m_we   = 1'b0;
                m_prot = 1'b0;
                m_rd_a = '0;
                m_rd_b = '0;
            end else if (m_age == 0) begin
                if (!m_we) begin
                    if (m_who) m_rd_b = ref_mem[m_addr];
                    else       m_rd_a = ref_mem[m_addr];
                end else if (!m_prot) begin
                    ref_mem[m_addr] = m_wdata;
                end
                m_age = 1;
            end else if (m_age == 1) begin
                m_age = -1;
            end else if (a_req || b_req) begin
                m_who   = (a_req && b_req) ? !m_last : b_req;
                m_last  = m_who;
                m_addr  = m_who ? b_addr  : a_addr;
                m_wdata = m_who ? b_wdata : a_wdata;
                m_we    = m_who ? b_we    : a_we;
                m_prot  = m_we && (m_addr >= 15'h1000) && (m_addr <= 15'h1FFF);
                m_age   = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                check("busy",    busy,              m_age != -1);
                check("mem_oe",  mem_output_enable, m_age == 0 && !m_we && !reset);
                check("mem_we",  mem_write_enable,  m_age == 0 && m_we && !m_prot && !reset);
                check("a_ack",   a_ack,             m_age == 1 && !m_who && !reset);
                check("b_ack",   b_ack,             m_age == 1 &&  m_who && !reset);
                check("a_err",   a_err,             m_age == 1 && !m_who && m_prot && !reset);
                check("b_err",   b_err,             m_age == 1 &&  m_who && m_prot && !reset);
                check("a_rdata", a_rdata,           m_rd_a);
                check("b_rdata", b_rdata,           m_rd_b);
                check("mem_addr", mem_address,      m_addr);
                check("mem_din", mem_data_in,       m_wdata);
            end
        end
    end

    // One complete access from IDLE; called just after a posedge with the DUT idle.
    task automatic xfer(input bit who, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd,
                        input bit exp_err, input string tag);
        if (who) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        end
        @(negedge clk);
        check({tag, "_c0_busy"}, busy, 1'b0);
        @(negedge clk);
        check({tag, "_c1_oe"}, mem_output_enable, !we);
        check({tag, "_c1_we"}, mem_write_enable, we && !exp_err);
        @(negedge clk);
        check({tag, "_c2_ack"}, who ? b_ack : a_ack, 1'b1);
        check({tag, "_c2_other_ack"}, who ? a_ack : b_ack, 1'b0);
        check({tag, "_c2_err"}, who ? b_err : a_err, exp_err);
        check({tag, "_c2_we_off"}, mem_write_enable, 1'b0);
        if (!we) check({tag, "_c2_rdata"}, who ? b_rdata : a_rdata, exp_rd);
        @(posedge clk); #1;
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",    busy,              1'b0);
        check("rst_a_rdata", a_rdata,           8'h00);
        check("rst_b_rdata", b_rdata,           8'h00);
        check("rst_a_ack",   a_ack,             1'b0);
        check("rst_b_ack",   b_ack,             1'b0);
        check("rst_oe",      mem_output_enable, 1'b0);
        check("rst_we",      mem_write_enable,  1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        // B read pre-loads b_rdata, then an A read must leave it untouched.
        xfer(1'b1, 1'b0, 15'h0300, 8'h00, 8'h33, 1'b0, "b_rd_0300");
        xfer(1'b0, 1'b0, 15'h1FFC, 8'h00, 8'h00, 1'b0, "a_rd_1ffc");
        check("b_rdata_kept", b_rdata, 8'h33);

        // Unprotected write followed by a read-back from the other requester.
        xfer(1'b1, 1'b1, 15'h0200, 8'h5A, 8'h00, 1'b0, "b_wr_0200");
        check("mem_0200", mem[15'h0200], 8'h5A);
        xfer(1'b0, 1'b0, 15'h0200, 8'h00, 8'h5A, 1'b0, "a_rd_0200");

        // Write into the protected window: completes with err, memory keeps 0x77.
        xfer(1'b1, 1'b1, 15'h1FFD, 8'hEA, 8'h00, 1'b1, "b_wr_prot");
        check("mem_1ffd", mem[15'h1FFD], 8'h77);
        xfer(1'b0, 1'b0, 15'h1FFD, 8'h00, 8'h77, 1'b0, "a_rd_1ffd");

        // Reset during a write's ACCESS cycle aborts it.
        b_req = 1'b1; b_we = 1'b1; b_addr = 15'h0400; b_wdata = 8'h99;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_we",   mem_write_enable, 1'b0);
        @(negedge clk);
        check("abort_ack",  b_ack,   1'b0);
        check("abort_err",  b_err,   1'b0);
        check("abort_busy", busy,    1'b0);
        check("abort_rd_a", a_rdata, 8'h00);
        check("mem_0400",   mem[15'h0400], 8'h00);
        @(posedge clk); #1;
        reset = 1'b0;
        b_req = 1'b0;

        // Both requesting from reset: A, then B, then A, acks every 3 cycles.
        a_req = 1'b1; a_we = 1'b0; a_addr = 15'h0200;
        b_req = 1'b1; b_we = 1'b0; b_addr = 15'h0300;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            check($sformatf("rr_a_ack_c%0d", c), a_ack, (c == 2) || (c == 8));
            check($sformatf("rr_b_ack_c%0d", c), b_ack, c == 5);
        end
        check("rr_a_rdata", a_rdata, 8'h5A);
        check("rr_b_rdata", b_rdata, 8'h33);
        @(posedge clk); #1;
        a_req = 1'b0;
        b_req = 1'b0;

        repeat (3) @(negedge clk);
        check("end_idle", busy, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15, memory address width.
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 Parameter WP_EN, default 0; 1 enables the write-protected (ROM) window.
REQ-004 Parameter WP_LO, default 15'h0000, lowest protected address (inclusive).
REQ-005 Parameter WP_HI, default 15'h7FFF, highest protected address (inclusive).
REQ-006 clk  in  1  single clock; all state updates on posedge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 a_req / b_req  in  1 each  access request from requester A (CPU) / B (DMA/loader).
REQ-009 a_we / b_we  in  1 each  1 = write, 0 = read.
REQ-010 a_addr / b_addr  in  ADDR_W each  access address.
REQ-011 a_wdata / b_wdata  in  DATA_W each  write data.
REQ-012 a_ack / b_ack  out  1 each  one-cycle completion pulse.
REQ-013 a_rdata / b_rdata  out  DATA_W each  registered read data, valid with ack.
REQ-014 a_err / b_err  out  1 each  pulses with ack when a write hit the protected window.
REQ-015 busy  out  1  high while state is not IDLE.
REQ-016 mem_write_enable, mem_output_enable  out  1 each  memory port strobes.
REQ-017 mem_address  out  ADDR_W; mem_data_in  out  DATA_W; mem_data_out  in  DATA_W (combinational memory read).

Function
REQ-018 FSM states IDLE, ACCESS, ACK; transitions IDLE->ACCESS when a_req|b_req, ACCESS->ACK unconditionally, ACK->IDLE unconditionally.
REQ-019 Requests are sampled only in IDLE; req levels in ACCESS/ACK are ignored.
REQ-020 In IDLE with one req high, that requester is granted; with both high, the requester not equal to last_grant wins (round-robin).
REQ-021 last_grant updates to the granted requester on every IDLE->ACCESS transition.
REQ-022 On grant, the winner's addr, we and wdata, plus a "protected" flag (WP_EN && WP_LO<=addr<=WP_HI && we), are latched into internal registers.
REQ-023 mem_address and mem_data_in are driven from the latched registers in all states.
REQ-024 In ACCESS: mem_output_enable=1 for a read; mem_write_enable=1 for a write with protected=0; both 0 otherwise.
REQ-025 mem_write_enable and mem_output_enable are 0 in IDLE and ACK, and forced 0 whenever reset is high.
REQ-026 At the posedge ending ACCESS: for a read, mem_data_out is captured into the granted requester's rdata; the other requester's rdata is unchanged; a write leaves both rdata unchanged.
REQ-027 In ACK, only the granted requester's ack is 1, for exactly one cycle; err is 1 with it iff protected=1.
REQ-028 Latency: req sampled high in IDLE at cycle 0 -> mem strobes in cycle 1 -> ack/rdata in cycle 2; max throughput one access per 3 cycles.
REQ-029 A requester holds req, we, addr and wdata stable until ack; req still high in the IDLE cycle after ACK is a new request.
REQ-030 A protected write does not modify memory but completes normally (ack + err).

Reset
REQ-031 While reset is high at a posedge: state=IDLE, last_grant=B (A wins the first tie), all ack/err=0, a_rdata=b_rdata=0, latched addr/wdata/we/protected=0, busy=0.
REQ-032 Reset asserted in ACCESS or ACK aborts the access: no ack or err is issued and no memory write occurs.

Verification
REQ-033 A read 0x1FFC with memory 0x00 there, a_req held -> mem_output_enable high cycle 1, a_ack and a_rdata=0x00 cycle 2, b_ack stays 0.
REQ-034 a_req and b_req both high from reset -> A granted first, then B (after A's ACK->IDLE), then A again; acks alternate every 3 cycles.
REQ-035 B writes 0x5A to 0x0200 (WP_EN=0), then A reads 0x0200 -> mem_write_enable high exactly one cycle; a_rdata=0x5A.
REQ-036 WP_EN=1, WP_LO=0x1000, WP_HI=0x1FFF; B writes 0xEA to 0x1FFD -> mem_write_enable stays 0, b_ack and b_err pulse together, subsequent read returns prior contents.
REQ-037 Reset asserted during a write's ACCESS cycle -> mem_write_enable 0, no ack, state IDLE, memory unchanged.
REQ-038 A read in progress, b_rdata pre-loaded with 0x33 -> b_rdata remains 0x33 after A's ack.
